// File: rtl/plcp_pkg.sv
// Shared 802.11a PLCP definitions: FSM state encoding, RATE codes and
// the RATE -> data-bits-per-symbol lookup used by transmitter and receiver.
package plcp_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_SIG_RATE,
        ST_SIG_RSVD,
        ST_SIG_LEN,
        ST_SIG_PARITY,
        ST_SIG_TAIL,
        ST_SERVICE,
        ST_DATA,
        ST_TAIL,
        ST_PAD
    } state_e;

    localparam logic [3:0] RATE_6M  = 4'b1101;
    localparam logic [3:0] RATE_9M  = 4'b1111;
    localparam logic [3:0] RATE_12M = 4'b0101;
    localparam logic [3:0] RATE_18M = 4'b0111;
    localparam logic [3:0] RATE_24M = 4'b1001;
    localparam logic [3:0] RATE_36M = 4'b1011;
    localparam logic [3:0] RATE_48M = 4'b0001;
    localparam logic [3:0] RATE_54M = 4'b0011;

    localparam int NDBPS_W = 8;

    localparam logic [NDBPS_W-1:0] NDBPS_6M  = 8'd24;
    localparam logic [NDBPS_W-1:0] NDBPS_9M  = 8'd36;
    localparam logic [NDBPS_W-1:0] NDBPS_12M = 8'd48;
    localparam logic [NDBPS_W-1:0] NDBPS_18M = 8'd72;
    localparam logic [NDBPS_W-1:0] NDBPS_24M = 8'd96;
    localparam logic [NDBPS_W-1:0] NDBPS_36M = 8'd144;
    localparam logic [NDBPS_W-1:0] NDBPS_48M = 8'd192;
    localparam logic [NDBPS_W-1:0] NDBPS_54M = 8'd216;

    // Returns {valid, ndbps}; unknown codes give all zeros.
    function automatic logic [NDBPS_W:0] rate_to_ndbps(input logic [3:0] rate);
        case (rate)
            RATE_6M:  return {1'b1, NDBPS_6M};
            RATE_9M:  return {1'b1, NDBPS_9M};
            RATE_12M: return {1'b1, NDBPS_12M};
            RATE_18M: return {1'b1, NDBPS_18M};
            RATE_24M: return {1'b1, NDBPS_24M};
            RATE_36M: return {1'b1, NDBPS_36M};
            RATE_48M: return {1'b1, NDBPS_48M};
            RATE_54M: return {1'b1, NDBPS_54M};
            default:  return '0;
        endcase
    endfunction

endpackage

// File: rtl/plcp_frame_tx_if.sv
// Request, PSDU handshake and serial output bundle of the PLCP transmitter.
interface plcp_frame_tx_if #(
    parameter int LEN_W = 12
);
    logic             Start;
    logic [3:0]       Rate;
    logic [LEN_W-1:0] Length;
    logic             DataIn;
    logic             DataValid;
    logic             DataReady;
    logic             Output;
    logic             OutValid;
    logic             ScrambleEn;
    logic             ScrambleInit;
    logic             Busy;
    logic             Done;
    logic             Error;

    modport master (
        output Start, Rate, Length, DataIn, DataValid,
        input  DataReady, Output, OutValid, ScrambleEn, ScrambleInit, Busy, Done, Error
    );

    modport slave (
        input  Start, Rate, Length, DataIn, DataValid,
        output DataReady, Output, OutValid, ScrambleEn, ScrambleInit, Busy, Done, Error
    );
endinterface

// File: rtl/plcp_rate_lut.sv
// Combinational RATE code decoder: validity flag and data bits per OFDM symbol.
module plcp_rate_lut
    import plcp_pkg::*;
(
    input  logic [3:0]         rate,
    output logic               valid,
    output logic [NDBPS_W-1:0] ndbps
);
    assign {valid, ndbps} = rate_to_ndbps(rate);
endmodule

// File: rtl/plcp_frame_tx.sv
// Serial 802.11a PLCP frame transmitter: preamble, SIGNAL, SERVICE, PSDU,
// tail and symbol pad, one registered bit per clock.
module plcp_frame_tx
    import plcp_pkg::*;
#(
    parameter int         PREAMBLE_BYTES = 12,
    parameter logic [7:0] PREAMBLE_BYTE  = 8'hAA,
    parameter int         LEN_W          = 12,
    parameter int         SERVICE_BITS   = 16,
    parameter int         TAIL_BITS      = 6
) (
    input logic            Clock,
    input logic            Reset,
    plcp_frame_tx_if.slave bus
);
    localparam int CNT_W = LEN_W + 3;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   bit_cnt_q;
    logic [NDBPS_W-1:0] sym_cnt_q, ndbps_q;
    logic [3:0]         rate_q;
    logic [LEN_W-1:0]   len_q;

    logic               rate_ok;
    logic [NDBPS_W-1:0] rate_ndbps;
    logic               start_ok, emit, sym_wrap, field_last, frame_last;
    logic               bit_d, scr_en_d;
    logic [7:0]         pre_sh;
    logic [3:0]         rate_sh;
    logic [LEN_W-1:0]   len_sh;
    logic               out_q, out_valid_q, scr_en_q, scr_init_q;
    logic               busy_q, done_q, error_q, ready_q;

    plcp_rate_lut u_rate_lut (
        .rate  (bus.Rate),
        .valid (rate_ok),
        .ndbps (rate_ndbps)
    );

    assign start_ok = bus.Start && rate_ok && (bus.Length != '0);
    // Only DATA can stall: a cycle without DataValid emits nothing.
    assign emit     = (state_q != ST_IDLE) && ((state_q != ST_DATA) || bus.DataValid);
    assign sym_wrap = (sym_cnt_q == ndbps_q - NDBPS_W'(1));

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            sym_cnt_q <= '0;
            ndbps_q   <= '0;
            rate_q    <= '0;
            len_q     <= '0;
        end else begin
            state_q <= state_d;
            if (state_d != state_q)
                bit_cnt_q <= '0;
            else if (emit)
                bit_cnt_q <= bit_cnt_q + CNT_W'(1);
            if (state_q == ST_IDLE) begin
                sym_cnt_q <= '0;
                if (start_ok) begin
                    rate_q  <= bus.Rate;
                    len_q   <= bus.Length;
                    ndbps_q <= rate_ndbps;
                end
            end else if (emit && (state_q inside {ST_SERVICE, ST_DATA, ST_TAIL, ST_PAD})) begin
                sym_cnt_q <= sym_wrap ? '0 : sym_cnt_q + NDBPS_W'(1);
            end
        end
    end

    // NOTE: every combinational output gets a default first so no path
    // through the case statement can infer a latch.
    always_comb begin
        state_d    = state_q;
        field_last = 1'b0;
        case (state_q)
            ST_PREAMBLE:               field_last = (bit_cnt_q == CNT_W'(8 * PREAMBLE_BYTES - 1));
            ST_SIG_RATE:               field_last = (bit_cnt_q == CNT_W'(3));
            ST_SIG_RSVD, ST_SIG_PARITY: field_last = 1'b1;
            ST_SIG_LEN:                field_last = (bit_cnt_q == CNT_W'(LEN_W - 1));
            ST_SIG_TAIL, ST_TAIL:      field_last = (bit_cnt_q == CNT_W'(TAIL_BITS - 1));
            ST_SERVICE:                field_last = (bit_cnt_q == CNT_W'(SERVICE_BITS - 1));
            ST_DATA:                   field_last = (bit_cnt_q == {len_q, 3'b000} - CNT_W'(1));
            default:                   field_last = 1'b0;
        endcase
        case (state_q)
            ST_IDLE:       if (start_ok)   state_d = ST_PREAMBLE;
            ST_PREAMBLE:   if (field_last) state_d = ST_SIG_RATE;
            ST_SIG_RATE:   if (field_last) state_d = ST_SIG_RSVD;
            ST_SIG_RSVD:                   state_d = ST_SIG_LEN;
            ST_SIG_LEN:    if (field_last) state_d = ST_SIG_PARITY;
            ST_SIG_PARITY:                 state_d = ST_SIG_TAIL;
            ST_SIG_TAIL:   if (field_last) state_d = ST_SERVICE;
            ST_SERVICE:    if (field_last) state_d = ST_DATA;
            ST_DATA:       if (emit && field_last) state_d = ST_TAIL;
            ST_TAIL:       if (field_last) state_d = sym_wrap ? ST_IDLE : ST_PAD;
            ST_PAD:        if (sym_wrap)   state_d = ST_IDLE;
            default:                       state_d = ST_IDLE;
        endcase
    end

    assign frame_last = (state_q != ST_IDLE) && (state_d == ST_IDLE);

    always_comb begin
        bit_d    = 1'b0;
        scr_en_d = 1'b0;
        pre_sh   = PREAMBLE_BYTE << bit_cnt_q[2:0];
        rate_sh  = rate_q << bit_cnt_q;
        len_sh   = len_q >> bit_cnt_q;
        case (state_q)
            ST_PREAMBLE:        bit_d    = pre_sh[7];
            ST_SIG_RATE:        bit_d    = rate_sh[3];
            ST_SIG_LEN:         bit_d    = len_sh[0];
            ST_SIG_PARITY:      bit_d    = ^{rate_q, len_q};
            ST_SERVICE, ST_PAD: scr_en_d = 1'b1;
            ST_DATA: begin
                bit_d    = bus.DataIn;
                scr_en_d = emit;
            end
            default: bit_d = 1'b0;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            out_q       <= 1'b0;
            out_valid_q <= 1'b0;
            scr_en_q    <= 1'b0;
            scr_init_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            ready_q     <= 1'b0;
        end else begin
            out_q       <= emit && bit_d;
            out_valid_q <= emit;
            scr_en_q    <= scr_en_d;
            scr_init_q  <= (state_q == ST_SERVICE) && (bit_cnt_q == '0);
            busy_q      <= (state_d != ST_IDLE);
            done_q      <= frame_last;
            error_q     <= (state_q == ST_IDLE) && bus.Start && !start_ok;
            ready_q     <= (state_d == ST_DATA);
        end
    end

    assign bus.Output       = out_q;
    assign bus.OutValid     = out_valid_q;
    assign bus.ScrambleEn   = scr_en_q;
    assign bus.ScrambleInit = scr_init_q;
    assign bus.Busy         = busy_q;
    assign bus.Done         = done_q;
    assign bus.Error        = error_q;
    assign bus.DataReady    = ready_q;
endmodule

// File: tb/tb_plcp_frame_tx.sv
// Directed bench for plcp_frame_tx: table of frames compared bit by bit
// against a frame built from hand-computed field sizes, plus reset abort.
module tb_plcp_frame_tx;
    import plcp_pkg::*;

    localparam int LEN_W   = 12;
    localparam int PB      = 12;
    localparam int SIG_END = 8 * PB + 4 + 1 + LEN_W + 1 + 6;

    logic Clock = 1'b0;
    logic Reset;
    always #5 Clock = ~Clock;

    plcp_frame_tx_if #(.LEN_W(LEN_W)) bus ();

    plcp_frame_tx #(
        .PREAMBLE_BYTES (PB),
        .PREAMBLE_BYTE  (8'hAA),
        .LEN_W          (LEN_W),
        .SERVICE_BITS   (16),
        .TAIL_BITS      (6)
    ) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    typedef struct {
        logic [3:0] rate;
        int         len;
        int         stall_at;
        int         stall_len;
        bit         poke;
        bit         exp_err;
        int         exp_field;
    } vec_t;

    int n_vec  = 0;
    int n_miss = 0;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic run_frame(input int k, input vec_t v);
        bit               exp_b[$];
        bit               exp_se[$];
        bit               data[];
        logic [7:0]       pre = 8'hAA;
        logic [LEN_W-1:0] lv = LEN_W'(v.len);
        int nbits = 8 * v.len;
        int got = 0, bad_b = 0, bad_se = 0, first_bad = -1;
        int gaps = 0, inits = 0, init_idx = -1, dones = 0, errs = 0;
        int busy_seen = 0, busy_done = 0, idx = 0, cyc = 0;
        int stall_left = v.stall_len;
        bit fin = 1'b0;
        string tag = $sformatf("v%0d", k);

        data = new[nbits > 0 ? nbits : 1];
        foreach (data[i]) data[i] = 1'($urandom);
        for (int i = 0; i < 8 * PB; i++) begin exp_b.push_back(pre[7 - (i % 8)]); exp_se.push_back(1'b0); end
        for (int i = 0; i < 4; i++) begin exp_b.push_back(v.rate[3 - i]); exp_se.push_back(1'b0); end
        exp_b.push_back(1'b0); exp_se.push_back(1'b0);
        for (int i = 0; i < LEN_W; i++) begin exp_b.push_back(lv[i]); exp_se.push_back(1'b0); end
        exp_b.push_back((^v.rate) ^ (^lv)); exp_se.push_back(1'b0);
        for (int i = 0; i < 6; i++) begin exp_b.push_back(1'b0); exp_se.push_back(1'b0); end
        for (int i = 0; i < 16; i++) begin exp_b.push_back(1'b0); exp_se.push_back(1'b1); end
        for (int i = 0; i < nbits; i++) begin exp_b.push_back(data[i]); exp_se.push_back(1'b1); end
        for (int i = 0; i < 6; i++) begin exp_b.push_back(1'b0); exp_se.push_back(1'b0); end
        for (int i = 0; i < v.exp_field - (16 + nbits + 6); i++) begin exp_b.push_back(1'b0); exp_se.push_back(1'b1); end

        @(negedge Clock);
        bus.Start = 1'b1; bus.Rate = v.rate; bus.Length = LEN_W'(v.len);
        bus.DataValid = 1'b1; bus.DataIn = 1'b0;
        @(negedge Clock);
        bus.Start = 1'b0;
        while (!fin && cyc < 40000) begin
            if (bus.Error) errs++;
            if (bus.Busy) busy_seen++;
            if (bus.ScrambleInit) begin inits++; init_idx = got; end
            if (bus.OutValid) begin
                if (got < exp_b.size()) begin
                    if (bus.Output !== exp_b[got]) begin bad_b++; if (first_bad < 0) first_bad = got; end
                    if (bus.ScrambleEn !== exp_se[got]) bad_se++;
                end
                got++;
            end else if (bus.Busy) begin
                gaps++;
            end
            if (bus.Done) begin dones++; busy_done = int'(bus.Busy); fin = 1'b1; end
            if (v.exp_err && cyc >= 4) fin = 1'b1;

            bus.Start = v.poke && (cyc == 10);
            if (bus.Start) begin bus.Rate = RATE_48M; bus.Length = LEN_W'(2); end
            if (bus.DataReady && idx == v.stall_at && stall_left > 0) begin
                bus.DataValid = 1'b0;
                stall_left--;
            end else begin
                bus.DataValid = 1'b1;
                bus.DataIn    = (idx < nbits) ? data[idx] : 1'b0;
                if (bus.DataReady) idx++;
            end
            if (!fin) begin
                @(negedge Clock);
                cyc++;
            end
        end
        bus.Start = 1'b0;

        if (v.exp_err) begin
            check({tag, ".error_pulses"}, errs, 1);
            check({tag, ".busy_cycles"}, busy_seen, 0);
            check({tag, ".out_bits"}, got, 0);
        end else begin
            check({tag, ".finished"}, int'(fin), 1);
            check({tag, ".error_pulses"}, errs, 0);
            check({tag, ".field_bits"}, got - SIG_END, v.exp_field);
            check({tag, ".bit_miss"}, bad_b, 0);
            if (bad_b != 0) $display("  %s first differing bit index %0d", tag, first_bad);
            check({tag, ".scr_en_miss"}, bad_se, 0);
            check({tag, ".scr_init_cnt"}, inits, 1);
            check({tag, ".scr_init_pos"}, init_idx, SIG_END);
            check({tag, ".done_cnt"}, dones, 1);
            check({tag, ".busy_at_done"}, busy_done, 0);
            check({tag, ".gap_cycles"}, gaps, 1 + v.stall_len);
            check({tag, ".bits_taken"}, idx, nbits);
        end
        repeat (3) @(negedge Clock);
    endtask

    task automatic reset_mid_frame();
        int got = 0, cyc = 0, dones = 0;
        @(negedge Clock);
        bus.Start = 1'b1; bus.Rate = RATE_6M; bus.Length = LEN_W'(1);
        @(negedge Clock);
        bus.Start = 1'b0;
        while (got < 8 * PB + 7 && cyc < 1000) begin
            if (bus.OutValid) got++;
            if (bus.Done) dones++;
            @(negedge Clock);
            cyc++;
        end
        check("rst.reached_siglen", int'(dut.state_q), int'(ST_SIG_LEN));
        Reset = 1'b1;
        @(negedge Clock);
        check("rst.outputs", int'({bus.Output, bus.OutValid, bus.ScrambleEn, bus.ScrambleInit,
                                   bus.Busy, bus.Done, bus.Error, bus.DataReady}), 0);
        check("rst.state", int'(dut.state_q), int'(ST_IDLE));
        Reset = 1'b0;
        repeat (4) begin
            @(negedge Clock);
            if (bus.Done) dones++;
        end
        check("rst.no_done", dones, 0);
    endtask

    vec_t vecs[9];

    initial begin
        vecs[0] = '{RATE_6M,  1,    -1, 0, 1'b0, 1'b0, 48};
        vecs[1] = '{RATE_54M, 100,  -1, 0, 1'b0, 1'b0, 864};
        vecs[2] = '{RATE_48M, 4095, -1, 0, 1'b0, 1'b0, 32832};
        vecs[3] = '{RATE_12M, 10,   40, 5, 1'b0, 1'b0, 144};
        vecs[4] = '{RATE_12M, 10,   -1, 0, 1'b0, 1'b0, 144};
        vecs[5] = '{4'b0000,  5,    -1, 0, 1'b0, 1'b1, 0};
        vecs[6] = '{RATE_9M,  0,    -1, 0, 1'b0, 1'b1, 0};
        vecs[7] = '{RATE_36M, 3,    -1, 0, 1'b1, 1'b0, 144};
        vecs[8] = '{RATE_18M, 20,   -1, 0, 1'b0, 1'b0, 216};

        Reset = 1'b1;
        bus.Start = 1'b0; bus.Rate = '0; bus.Length = '0;
        bus.DataIn = 1'b0; bus.DataValid = 1'b0;
        repeat (3) @(negedge Clock);
        check("reset.outputs", int'({bus.Output, bus.OutValid, bus.ScrambleEn, bus.ScrambleInit,
                                     bus.Busy, bus.Done, bus.Error, bus.DataReady}), 0);
        check("reset.state", int'(dut.state_q), int'(ST_IDLE));
        Reset = 1'b0;
        @(negedge Clock);

        for (int k = 0; k < 9; k++) run_frame(k, vecs[k]);
        reset_mid_frame();
        run_frame(9, vecs[0]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule

// File: doc/plcp_frame_tx.md
Name: plcp_frame_tx

Overview:
- Parametrised successor to the serial 802.11a PLCP transmitter FSM.
- Emits one bit per Clock in this order: the full PLCP frame preamble, the SIGNAL field (RATE, reserved, LENGTH, parity, tail), then SERVICE, PSDU data, tail and pad bits.
- RATE and LENGTH are runtime inputs latched at Start, not constants. PSDU bits arrive over a valid/ready handshake.
- ScrambleEn and ScrambleInit drive the existing Scrambler downstream. Output feeds the convolutional encoder stage.

Parameters:
- PREAMBLE_BYTES, 12, number of preamble octets sent.
- PREAMBLE_BYTE, 8'hAA, octet pattern, MSB first.
- LEN_W, 12, LENGTH field width (octets).
- SERVICE_BITS, 16, SERVICE field length (all zero).
- TAIL_BITS, 6, zero tail length for SIGNAL and DATA.

Ports:
- Clock  in  1  rising-edge clock
- Reset  in  1  synchronous, active-high reset
- Start  in  1  one-cycle request; sampled only in IDLE
- Rate  in  4  RATE code R1..R4 (Rate[3]=R1)
- Length  in  LEN_W  PSDU octet count
- DataIn  in  1  PSDU bit
- DataValid  in  1  DataIn valid
- DataReady  out  1  block accepts DataIn this cycle
- Output  out  1  serial frame bit
- OutValid  out  1  Output valid this cycle
- ScrambleEn  out  1  Output bit is to be scrambled
- ScrambleInit  out  1  one-cycle pulse to reseed scrambler
- Busy  out  1  frame in progress
- Done  out  1  one-cycle pulse after last bit
- Error  out  1  one-cycle pulse: Start rejected

Behaviour:
- Reset (synchronous) values: all outputs 0; state IDLE; all counters 0. Reset asserted mid-frame aborts the frame; no Done pulse is generated.
- Outputs are registered. A bit chosen in state S at edge k appears on Output/OutValid after edge k+1.
- Start sampled in IDLE:
  - Rate must be one of 1101, 1111, 0101, 0111, 1001, 1011, 0001, 0011, and Length must be non-zero.
  - Invalid: pulse Error, stay IDLE.
  - Valid: latch Rate, Length and N_DBPS, set Busy, go to PREAMBLE.
  - N_DBPS by code: 1101→24, 1111→36, 0101→48, 0111→72, 1001→96, 1011→144, 0001→192, 0011→216.
- Start outside IDLE is ignored.
- States and transitions:
  - IDLE.
  - PREAMBLE: 8·PREAMBLE_BYTES bits, MSB of each octet first.
  - SIG_RATE: 4 bits, R1 first.
  - SIG_RSVD: 1 bit, 0.
  - SIG_LEN: LEN_W bits, LSB first.
  - SIG_PARITY: 1 bit, even parity over RATE, reserved and LENGTH.
  - SIG_TAIL: TAIL_BITS zeros.
  - SERVICE: SERVICE_BITS zeros.
  - DATA: 8·Length bits.
  - TAIL: TAIL_BITS zeros.
  - PAD: zeros.
  - IDLE again.
- ScrambleInit pulses on the cycle the first SERVICE bit is presented on Output.
- ScrambleEn is 1 for SERVICE, DATA and PAD bits, 0 otherwise.
- DATA handshake:
  - DataReady = 1 only in DATA.
  - A bit transfers when DataValid && DataReady. The transferred bit appears on Output next cycle with OutValid=1.
  - If DataValid=0, OutValid=0 next cycle and the bit and symbol counters hold (stall, no bit lost).
- OutValid is 1 for every emitted bit in all other states; there is no stall outside DATA.
- Pad computation:
  - A symbol-bit counter runs 0..N_DBPS-1, starts at the first SERVICE bit, and advances on every emitted bit of SERVICE, DATA, TAIL and PAD. It wraps to 0.
  - PAD continues until the counter wraps.
  - If the counter is 0 on leaving TAIL, PAD is skipped.
  - Result: total DATA-field bits = ceil((SERVICE_BITS + 8·Length + TAIL_BITS)/N_DBPS)·N_DBPS.
- On the last bit (PAD, or TAIL if no pad): return to IDLE and clear Busy. Done pulses in the same cycle that bit is on Output.
- Length counter width: LEN_W+3 bits. There is no overflow at maximum Length.

Decomposition:
- Shared package plcp_pkg holds:
  - the state enum (4-bit encoding);
  - the RATE code constants;
  - the N_DBPS widths;
  - function rate_to_ndbps returning {valid, ndbps[7:0]}.
- One sub-module, plcp_rate_lut: combinational Rate → {valid, N_DBPS}. It is reused later by the receiver SIGNAL decoder.

Test Plan:
- Rate=1101, Length=1, DataValid always 1:
  - 96 bits 1010…;
  - SIGNAL bits 1,1,0,1,0,1,0×11,parity 0,0×6;
  - data field 48 bits (18 pad);
  - 168 OutValid cycles, then Done.
- Rate=0011, Length=100, random data:
  - data field 864 bits (pad 42);
  - DATA bits match input in order;
  - ScrambleInit exactly once.
- Rate=0001, Length=4095: parity bit 1; data field is a multiple of 192 bits; no counter overflow.
- Stall: DataValid=0 for 5 cycles mid-DATA → OutValid=0 for exactly 5 cycles; frame otherwise identical to the no-stall reference.
- Start with Rate=0000, or with Length=0 → Error pulse, Busy stays 0. A second Start during Busy is ignored.
- Reset asserted in SIG_LEN → next cycle all outputs 0 and state IDLE. A fresh Start then produces a complete correct frame.
